// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the Pong rally sequencer and the ball/paddle/score blocks.
// The master side feeds frame pacing, button and miss flags; the slave is the sequencer.
interface pong_game_ctrl_if;
  logic       frame_tick;
  logic       start;
  logic       miss_left;
  logic       miss_right;
  logic       game_over;
  logic       ball_run;
  logic       ball_center;
  logic       serve_dir;
  logic       score_miss_left;
  logic       score_miss_right;
  logic       score_clear;
  logic [2:0] state;

  modport master (
    output frame_tick, start, miss_left, miss_right, game_over,
    input  ball_run, ball_center, serve_dir,
    input  score_miss_left, score_miss_right, score_clear, state
  );

  modport slave (
    input  frame_tick, start, miss_left, miss_right, game_over,
    output ball_run, ball_center, serve_dir,
    output score_miss_left, score_miss_right, score_clear, state
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Rally sequencer: idle -> serve hold -> play -> point pause -> serve/over,
// paced by the frame tick, with all outputs registered alongside the state.
module pong_game_ctrl #(
  parameter int SERVE_FRAMES = 60,
  parameter int PAUSE_FRAMES = 90
) (
  input logic              i_clk,
  input logic              i_reset,
  pong_game_ctrl_if.slave  io_bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam logic [7:0] LP_SERVE = 8'(SERVE_FRAMES);
  localparam logic [7:0] LP_PAUSE = 8'(PAUSE_FRAMES);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_start_q;
  logic       r_ball_run;
  logic       r_ball_center;
  logic       r_serve_dir;
  logic       r_miss_l;
  logic       r_miss_r;
  logic       r_clear;

  logic w_start_edge;
  logic w_last_tick;

  assign w_start_edge = io_bus.start & ~r_start_q;
  assign w_last_tick  = io_bus.frame_tick && (r_cnt == 8'd1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      // start_q comes up high so a button held through reset is not an edge
      r_state       <= S_IDLE;
      r_cnt         <= 8'd0;
      r_start_q     <= 1'b1;
      r_ball_run    <= 1'b0;
      r_ball_center <= 1'b1;
      r_serve_dir   <= 1'b1;
      r_miss_l      <= 1'b0;
      r_miss_r      <= 1'b0;
      r_clear       <= 1'b0;
    end else begin
      r_start_q <= io_bus.start;
      r_miss_l  <= 1'b0;
      r_miss_r  <= 1'b0;
      r_clear   <= 1'b0;

      case (r_state)
        S_IDLE, S_OVER: begin
          if (w_start_edge) begin
            r_state     <= S_SERVE;
            r_cnt       <= LP_SERVE;
            r_serve_dir <= 1'b1;
            r_clear     <= 1'b1;
          end
        end

        S_SERVE: begin
          if (io_bus.frame_tick) begin
            r_cnt <= r_cnt - 8'd1;
            if (w_last_tick) begin
              r_state       <= S_PLAY;
              r_ball_run    <= 1'b1;
              r_ball_center <= 1'b0;
            end
          end
        end

        S_PLAY: begin
          // left miss wins a tie; conceding player receives the next serve
          if (io_bus.miss_left || io_bus.miss_right) begin
            r_state       <= S_POINT;
            r_cnt         <= LP_PAUSE;
            r_ball_run    <= 1'b0;
            r_ball_center <= 1'b1;
            r_serve_dir   <= ~io_bus.miss_left;
            r_miss_l      <= io_bus.miss_left;
            r_miss_r      <= ~io_bus.miss_left;
          end
        end

        S_POINT: begin
          if (io_bus.frame_tick) begin
            r_cnt <= r_cnt - 8'd1;
            if (w_last_tick) begin
              if (io_bus.game_over) begin
                r_state <= S_OVER;
              end else begin
                r_state <= S_SERVE;
                r_cnt   <= LP_SERVE;
              end
            end
          end
        end

        default: begin
          r_state       <= S_IDLE;
          r_ball_run    <= 1'b0;
          r_ball_center <= 1'b1;
        end
      endcase
    end
  end

  assign io_bus.state            = r_state;
  assign io_bus.ball_run         = r_ball_run;
  assign io_bus.ball_center      = r_ball_center;
  assign io_bus.serve_dir        = r_serve_dir;
  assign io_bus.score_miss_left  = r_miss_l;
  assign io_bus.score_miss_right = r_miss_r;
  assign io_bus.score_clear      = r_clear;

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Top-level rally sequencer for the Pong core. It sits between the ball/paddle datapath and the score block. It converts the player start button and the ball's miss flags into a serve / play / point-pause / game-over sequence paced by the video frame tick. It drives the score block with single-cycle miss pulses and a score-clear pulse, and tells the ball logic when to hold at centre, when to run and which way to serve.

## Interface
- SERVE_FRAMES, default 60: frame ticks the ball is held at centre before a serve; legal range 1..255.
- PAUSE_FRAMES, default 90: frame ticks of pause after a point; legal range 1..255.
- clk  in  1  system clock, single clock domain.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- start  in  1  player start button, level, already debounced; rising edge detected internally.
- miss_left  in  1  ball passed the left paddle (level or pulse).
- miss_right  in  1  ball passed the right paddle (level or pulse).
- game_over  in  1  from score block; winning score reached.
- ball_run  out  1  ball motion enabled.
- ball_center  out  1  hold ball at screen centre.
- serve_dir  out  1  0 = serve toward left player, 1 = serve toward right player.
- score_miss_left  out  1  one-cycle pulse to score block.
- score_miss_right  out  1  one-cycle pulse to score block.
- score_clear  out  1  one-cycle pulse; clears both scores.
- state  out  3  current state code, for debug/LEDs.

## Operation
- States and codes: IDLE=0, SERVE=1, PLAY=2, POINT=3, OVER=4. Codes 5..7 are unreachable; if entered, go to IDLE.
- All outputs are registered (Moore). Per-state outputs:
  - ball_center=1 in IDLE, SERVE, POINT and OVER.
  - ball_run=1 only in PLAY.
- Start edge detection:
  - start_q <= start each cycle.
  - Edge = start & ~start_q.
  - start_q resets to 1, so a button held through reset does not start a game.
- IDLE or OVER, on a start edge:
  - Next state SERVE.
  - score_clear=1 for exactly that one cycle.
  - serve_dir <= 1.
  - cnt <= SERVE_FRAMES.
- SERVE:
  - cnt decrements on each frame_tick.
  - A frame_tick seen while cnt==1 moves the FSM to PLAY.
  - SERVE therefore lasts exactly SERVE_FRAMES ticks.
- PLAY, on miss_left:
  - Next state POINT.
  - score_miss_left=1 for one cycle.
  - serve_dir <= 0 (the player who conceded receives the next serve).
  - cnt <= PAUSE_FRAMES.
- PLAY, on miss_right: same as miss_left with score_miss_right=1 and serve_dir <= 1.
- PLAY, miss_left and miss_right both set in the same cycle: left has priority. Only score_miss_left pulses.
- POINT:
  - cnt decrements on frame_tick.
  - On the frame_tick while cnt==1, sample game_over: 1 goes to OVER; 0 goes to SERVE with cnt <= SERVE_FRAMES and serve_dir kept.
  - game_over asserting earlier in POINT does not cut the pause short.
- Input qualification:
  - Miss inputs are ignored outside PLAY. A level miss held into POINT produces no further pulses.
  - Start edges are ignored in SERVE, PLAY and POINT.
  - frame_tick is ignored in IDLE, PLAY and OVER.
- cnt is 8 bits, unsigned, decrement only. It never wraps: every exit happens at cnt==1.

## Timing
- Reset values:
  - state=IDLE(0), cnt=0, start_q=1.
  - ball_run=0, ball_center=1, serve_dir=1.
  - score_miss_left=0, score_miss_right=0, score_clear=0.
- Reset mid-operation: state returns to IDLE on the next edge.
  - No score_clear is emitted; scores persist until the next start.
  - Any in-flight pulse is dropped.
- start rising at edge N is registered at edge N+1. At that edge state becomes SERVE and score_clear is high for the cycle after N+1.
- A miss asserted before edge N gives state=POINT and a score_miss_* pulse in the same cycle after N. Latency is 1 cycle.
- The score block updates game_over by the next edge. POINT is at least one frame long, so game_over is always valid when sampled.
- SERVE→PLAY and POINT→SERVE/OVER transitions occur on the clock edge that samples the qualifying frame_tick.

## Test plan
- Reset then idle:
  - Hold reset 2 cycles with start=1, then release with start held.
  - Required: state=0, ball_center=1, ball_run=0, serve_dir=1, no score_clear.
- Start and serve (SERVE_FRAMES=3):
  - Apply a start edge.
  - Required: one score_clear pulse, state=1.
  - Required: state=2 and ball_run=1 after exactly the 3rd frame_tick, not the 2nd.
- Left miss then serve (PAUSE_FRAMES=2):
  - Drive miss_left high for 3 cycles in PLAY.
  - Required: exactly one score_miss_left pulse, state=3, serve_dir=0.
  - Required: state=1 after 2 ticks with game_over=0, then state=2 after 3 more ticks.
- Simultaneous miss:
  - Assert miss_left and miss_right together in PLAY.
  - Required: score_miss_left=1, score_miss_right=0, serve_dir=0.
- Game over:
  - Hold game_over=1 at the end of the POINT pause.
  - Required: state=4.
  - Required: a start edge during POINT is ignored; a start edge in OVER gives score_clear and state=1 with serve_dir=1.
- Reset mid-play:
  - Assert reset 1 cycle in PLAY.
  - Required: state=0 next cycle, ball_run=0, no score pulses.
